// File: rtl/reg_bus_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bus_arbiter
//
// Round-robin arbiter that shares one register bus between NUM_REQ
// requesters. Each requester holds a single read or write on req_valid
// until it sees its req_done pulse. Transactions go onto the bus one at a
// time, and each completion is reported back to its own requester.
//
// Optional feature:
//   REG_BUS_ARB_TIMEOUT_EN - when defined, a BUS phase that waits TIMEOUT
//   cycles without bus_ready is aborted. The requester then gets req_done
//   with req_err=1 and req_rdata=0. When undefined, BUS waits forever and
//   req_err is tied to 0.
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   ADDR_W   register address width
//   DATA_W   register data width
//   TIMEOUT  BUS-cycle limit before an abort (timeout build only)
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   req_valid  per-requester request, held until its req_done
//   req_rw     per-requester direction, 1 = write, 0 = read
//   req_addr   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata  packed write data, requester i at [i*DATA_W +: DATA_W]
//   req_done   one-hot, one-cycle completion pulse
//   req_rdata  read data, meaningful only while req_done is nonzero
//   req_err    timeout flag, meaningful only while req_done is nonzero
//   grant      one-hot current owner, zero when idle
//   bus_valid  bus transaction active
//   bus_rw     latched transaction direction
//   bus_addr   latched transaction address
//   bus_wdata  latched transaction write data
//   bus_ready  slave accepts/completes the transaction this cycle
//   bus_rdata  slave read data, sampled together with bus_ready
// ---------------------------------------------------------------------------
module reg_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      req_err,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      bus_valid,
  output logic                      bus_rw,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [DATA_W-1:0]         bus_wdata,
  input  logic                      bus_ready,
  input  logic [DATA_W-1:0]         bus_rdata
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   gidx;
  logic [PTR_W-1:0]   ptr_next;

  // Arbitration result for the current IDLE cycle
  logic               pick_vld;
  logic [PTR_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               sel_rw;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  // Round-robin search: the first requester at or after ptr, with wrap.
  // The index is folded back into range by subtraction rather than a
  // modulo, so NUM_REQ need not be a power of two.
  always_comb begin
    int               j;
    logic [PTR_W-1:0] jj;
    j        = 0;
    jj       = '0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      jj = PTR_W'(j);
      if (!pick_vld && req_valid[jj]) begin
        pick_vld = 1'b1;
        pick_idx = jj;
      end
    end
  end

  // Mux the winner's transaction fields out of the packed request buses
  always_comb begin
    pick_onehot = '0;
    sel_rw      = 1'b0;
    sel_addr    = '0;
    sel_wdata   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == pick_idx) begin
        pick_onehot[i] = pick_vld;
        sel_rw         = req_rw[i];
        sel_addr       = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata      = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_next = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + PTR_W'(1);

`ifdef REG_BUS_ARB_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_nxt;
  logic            err_q;

  assign to_cnt_nxt = to_cnt + TO_W'(1);
  assign req_err    = err_q;
`else
  // TIMEOUT is only meaningful in the timeout build
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign req_err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gidx      <= '0;
      grant     <= '0;
      bus_valid <= 1'b0;
      bus_rw    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      req_done  <= '0;
      req_rdata <= '0;
`ifdef REG_BUS_ARB_TIMEOUT_EN
      to_cnt    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        // ---- IDLE: sample requests, latch winner onto the bus ----
        IDLE: begin
          req_done  <= '0;
          req_rdata <= '0;
`ifdef REG_BUS_ARB_TIMEOUT_EN
          err_q     <= 1'b0;
`endif
          if (pick_vld) begin
            state     <= BUS;
            gidx      <= pick_idx;
            grant     <= pick_onehot;
            bus_valid <= 1'b1;
            bus_rw    <= sel_rw;
            bus_addr  <= sel_addr;
            bus_wdata <= sel_wdata;
`ifdef REG_BUS_ARB_TIMEOUT_EN
            to_cnt    <= '0;
`endif
          end
        end

        // ---- BUS: hold fields until the slave responds ----
        BUS: begin
          if (bus_ready) begin
            // Writes capture bus_rdata too; the requester ignores it
            state     <= DONE;
            bus_valid <= 1'b0;
            req_done  <= grant;
            req_rdata <= bus_rdata;
`ifdef REG_BUS_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
          end else begin
            to_cnt <= to_cnt_nxt;
            // A ready arriving in the limit cycle takes the branch above,
            // so a late-but-on-time slave still completes normally
            if (to_cnt_nxt == TO_W'(TIMEOUT)) begin
              state     <= DONE;
              bus_valid <= 1'b0;
              req_done  <= grant;
              req_rdata <= '0;
              err_q     <= 1'b1;
            end
`endif
          end
        end

        // ---- DONE: completion pulse, advance round-robin pointer ----
        DONE: begin
          state     <= IDLE;
          req_done  <= '0;
          req_rdata <= '0;
          grant     <= '0;
          ptr       <= ptr_next;
`ifdef REG_BUS_ARB_TIMEOUT_EN
          err_q     <= 1'b0;
`endif
        end

        default: begin
          state     <= IDLE;
          grant     <= '0;
          bus_valid <= 1'b0;
          req_done  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_bus_arbiter.md
# reg_bus_arbiter

Round-robin arbiter that shares one register bus (the slave side driving `my_reg`) between `NUM_REQ` independent requesters such as test programs, a config loader and a debug port. Each requester presents a single read or write and holds it until acknowledged. The arbiter serializes these transactions onto the bus, one outstanding at a time, and returns read data and completion per requester. It sits between the requesters and the register bus master modport, in the same `clk` domain as `reg_if`.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `ADDR_W`, 8, register address width
- `DATA_W`, 16, register data width
- `TIMEOUT`, 15, max cycles in BUS before abort (used only with macro)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_REQ  per-requester request, held until its `req_done`
- `req_rw`  in  NUM_REQ  1 = write, 0 = read
- `req_addr`  in  NUM_REQ*ADDR_W  requester i at `[i*ADDR_W +: ADDR_W]`
- `req_wdata`  in  NUM_REQ*DATA_W  requester i at `[i*DATA_W +: DATA_W]`
- `req_done`  out  NUM_REQ  one-hot, one-cycle completion pulse
- `req_rdata`  out  DATA_W  read data, valid only while `req_done` nonzero
- `req_err`  out  1  timeout flag, valid only while `req_done` nonzero
- `grant`  out  NUM_REQ  one-hot current owner, zero when idle
- `bus_valid`  out  1  bus transaction active
- `bus_rw`, `bus_addr`, `bus_wdata`  out  1/ADDR_W/DATA_W  latched transaction fields
- `bus_ready`  in  1  slave accepts/completes transaction this cycle
- `bus_rdata`  in  DATA_W  slave read data, sampled when `bus_ready`

## Operation
- FSM states: IDLE, BUS, DONE.
- IDLE: if any `req_valid`, select the first set bit searching from `ptr` upward with wrap. Latch index into `grant`, and latch rw/addr/wdata into the bus registers. Go to BUS. Otherwise stay.
- BUS: `bus_valid`=1 with fields stable. On `bus_ready`=1, capture `bus_rdata` (writes capture it too; requester ignores it). Go to DONE.
- DONE: `bus_valid`=0, `req_done[g]`=1, `req_rdata`=captured. `ptr` <= (g+1) mod NUM_REQ. Go to IDLE. `grant` clears on entry to IDLE.
- Request inputs are sampled only in IDLE. Changes while granted are ignored.
- Requester must drop `req_valid` on the edge ending the `req_done` cycle. A `req_valid` still high in the following IDLE cycle is a new transaction.
- Reset values: state IDLE, `ptr`=0, all outputs 0.
- `rst` mid-transaction: outputs go to 0 on the next edge. No `req_done` is issued for the aborted transaction, and `ptr` returns to 0.

## Timing
- `req_valid` high in IDLE cycle 0 -> `grant`, `bus_valid` high in cycle 1.
- `bus_ready` high in cycle k (k>=1) -> `req_done`/`req_rdata` in cycle k+1 -> IDLE in cycle k+2.
- Minimum transaction period is 3 cycles (BUS, DONE, IDLE), so best-case throughput is one transaction per 3 cycles.
- Fairness: with all requesters continuously active, each is served exactly once per NUM_REQ transactions.
- `bus_ready` while not in BUS is ignored.

## Configuration
- `REG_BUS_ARB_TIMEOUT_EN` defined:
  - A 4+-bit counter clears on entry to BUS and increments each BUS cycle without `bus_ready`.
  - When it reaches `TIMEOUT`, the FSM leaves BUS for DONE with `req_err`=1 and `req_rdata`=0.
  - `bus_ready` in the same cycle as the limit wins, giving a normal completion with `req_err`=0.
- Undefined: no counter. BUS waits indefinitely and `req_err` is tied to 0.

## Test plan
- Write from requester 2, addr 0x10, wdata 0xBEEF, `bus_ready` in the first BUS cycle -> bus shows rw=1/0x10/0xBEEF with `grant`=4'b0100. `req_done`=4'b0100 for exactly one cycle two cycles after `req_valid`.
- All four requesters assert together after reset, `bus_ready` always 1 -> grants in order 0,1,2,3, each `req_done` exactly once, 3 cycles apart.
- Read from requester 1, addr 0x20, `bus_ready` after 5 BUS cycles with `bus_rdata`=0x1234 -> `req_rdata`=0x1234 and `req_err`=0 in the `req_done` cycle.
- Requester 0 re-requests continuously, requester 3 asserts during 0's BUS phase -> serve order 0,3,0. Requester 3 is never starved.
- `rst` pulsed for one cycle in BUS -> next cycle `bus_valid`=0 and `grant`=0, with no `req_done`. With requests 0 and 2 pending, requester 0 is granted first after release.
- Macro defined, `TIMEOUT`=15, `bus_ready` held 0 -> DONE after 15 BUS cycles with `req_err`=1 and `req_rdata`=0. Macro undefined -> `bus_valid` stays 1 for 100+ cycles with no `req_done`.
